// File: rtl/vdu_wb_bridge.sv
// Wishbone-to-VDU bridge: posts writes into a 2-entry FIFO and serialises all
// VDU accesses through one drain FSM, with a read never overtaking a queued write.
module vdu_wb_bridge #(
  parameter logic [7:0] TMO_MAX     = 8'd255,
  parameter int         WFIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [10:0] wb_adr_i,
  input  logic [1:0]  wb_sel_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        vdu_cs,
  output logic        vdu_we,
  output logic        byte_m,
  output logic [11:0] vdu_addr,
  output logic [15:0] wr_data,
  input  logic [15:0] rd_data,
  input  logic        ready,
  output logic        tmo_err
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_ACC, S_WAIT_DONE, S_FIN} state_t;

  // {byte_m, byte address, lane-placed write data}
  function automatic logic [28:0] lane_map(input logic [10:0] adr, input logic [1:0] sel,
                                           input logic [15:0] dat);
    case (sel)
      2'b01:   return {1'b1, adr, 1'b0, 8'h00, dat[7:0]};
      2'b10:   return {1'b1, adr, 1'b1, dat[15:8], 8'h00};
      default: return {1'b0, adr, 1'b0, dat};
    endcase
  endfunction

  function automatic logic [15:0] rd_place(input logic [1:0] sel, input logic [15:0] d);
    case (sel)
      2'b01:   return {8'h00, d[7:0]};
      2'b10:   return {d[7:0], 8'h00};
      default: return d;
    endcase
  endfunction

  state_t       state_q, state_d;
  logic [7:0]   tcnt_q, tcnt_d, tcnt_inc;
  logic [1:0]   fcnt_q, fcnt_d;
  logic         wptr_q, rptr_q;
  logic [28:0]  fifo_q [2];
  logic [28:0]  lm;
  logic [1:0]   rd_sel_q;
  logic         ack_q, ack_d;
  logic [15:0]  dat_q, dat_d;
  logic         tmo_err_q, acc_tmo_q, cur_rd_q, rd_abort_q;
  logic         vdu_we_q, byte_m_q;
  logic [11:0]  vdu_addr_q;
  logic [15:0]  wr_data_q;
  logic         req, wr_req, rd_req, nul_req, full, empty, push, pop;
  logic         start_wr, start_rd, tmo_hit, fin_rd_ack;

  assign lm       = lane_map(wb_adr_i, wb_sel_i, wb_dat_i);
  assign req      = wb_cyc_i & wb_stb_i & ~ack_q;
  assign nul_req  = req & (wb_sel_i == 2'b00);
  assign wr_req   = req & wb_we_i & (wb_sel_i != 2'b00);
  assign rd_req   = req & ~wb_we_i & (wb_sel_i != 2'b00);
  assign full     = (fcnt_q == 2'(WFIFO_DEPTH));
  assign empty    = (fcnt_q == 2'd0);
  // The in-flight write stays at the FIFO head until its FIN, so a pop frees a slot
  assign pop      = (state_q == S_FIN) & ~cur_rd_q;
  assign push     = wr_req & (~full | pop);
  assign tcnt_inc = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    start_wr = 1'b0;
    start_rd = 1'b0;
    tmo_hit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          start_wr = 1'b1;
          tcnt_d   = 8'd0;
          state_d  = S_ISSUE;
        end else if (rd_req) begin
          start_rd = 1'b1;
          tcnt_d   = 8'd0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE:     state_d = ready ? S_WAIT_ACC : S_WAIT_DONE;
      S_WAIT_ACC: begin
        tcnt_d = tcnt_inc;
        if (!ready) begin
          state_d = S_WAIT_DONE;
        end else if ({1'b0, tcnt_q} + 9'd1 >= {1'b0, TMO_MAX}) begin
          tmo_hit = 1'b1;
          state_d = S_FIN;
        end
      end
      S_WAIT_DONE: if (ready) state_d = S_FIN;
      S_FIN:       state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fin_rd_ack = (state_q == S_FIN) & cur_rd_q & ~rd_abort_q & req & ~wb_we_i;
    ack_d      = 1'b0;
    dat_d      = dat_q;
    case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + 2'd1;
      2'b01:   fcnt_d = fcnt_q - 2'd1;
      default: fcnt_d = fcnt_q;
    endcase
    if (fin_rd_ack) begin
      ack_d = 1'b1;
      dat_d = acc_tmo_q ? 16'hFFFF : rd_place(rd_sel_q, rd_data);
    end else if (nul_req) begin
      ack_d = 1'b1;
      if (!wb_we_i) dat_d = 16'h0000;
    end else if (push) begin
      ack_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tcnt_q     <= 8'd0;
      fcnt_q     <= 2'd0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= 16'h0000;
      tmo_err_q  <= 1'b0;
      acc_tmo_q  <= 1'b0;
      cur_rd_q   <= 1'b0;
      rd_abort_q <= 1'b0;
      vdu_we_q   <= 1'b1;
      byte_m_q   <= 1'b0;
      vdu_addr_q <= 12'h000;
      wr_data_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      fcnt_q  <= fcnt_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      if (push) wptr_q <= ~wptr_q;
      if (pop)  rptr_q <= ~rptr_q;
      if (tmo_hit) begin
        tmo_err_q <= 1'b1;
        acc_tmo_q <= 1'b1;
      end
      // VDU-side fields load only on IDLE->ISSUE, so they hold for the whole access
      if (start_wr) begin
        cur_rd_q   <= 1'b0;
        acc_tmo_q  <= 1'b0;
        rd_abort_q <= 1'b0;
        vdu_we_q   <= 1'b0;
        {byte_m_q, vdu_addr_q, wr_data_q} <= fifo_q[rptr_q];
      end else if (start_rd) begin
        cur_rd_q   <= 1'b1;
        acc_tmo_q  <= 1'b0;
        rd_abort_q <= 1'b0;
        vdu_we_q   <= 1'b1;
        byte_m_q   <= lm[28];
        vdu_addr_q <= lm[27:16];
      end else if (cur_rd_q && state_q != S_IDLE && !(wb_cyc_i && wb_stb_i)) begin
        rd_abort_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)     fifo_q[wptr_q] <= lm;
    if (start_rd) rd_sel_q       <= wb_sel_i;
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign vdu_cs   = (state_q == S_ISSUE) || (state_q == S_WAIT_ACC);
  assign vdu_we   = vdu_we_q;
  assign byte_m   = byte_m_q;
  assign vdu_addr = vdu_addr_q;
  assign wr_data  = wr_data_q;
  assign tmo_err  = tmo_err_q;

endmodule

// File: tb/tb_vdu_wb_bridge.sv
// Bench for vdu_wb_bridge: random Wishbone traffic against a byte-memory model,
// a behavioural VDU responder, and directed ordering/timeout/reset scenarios.
module tb_vdu_wb_bridge;
  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [10:0] wb_adr_i;
  logic [1:0]  wb_sel_i;
  logic [15:0] wb_dat_i, wb_dat_o;
  logic        wb_ack_o;
  logic        vdu_cs, vdu_we, byte_m;
  logic [11:0] vdu_addr;
  logic [15:0] wr_data, rd_data;
  logic        ready;
  logic        tmo_err;

  always #5 clk = ~clk;

  vdu_wb_bridge dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .vdu_cs(vdu_cs), .vdu_we(vdu_we), .byte_m(byte_m), .vdu_addr(vdu_addr),
    .wr_data(wr_data), .rd_data(rd_data), .ready(ready), .tmo_err(tmo_err)
  );

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic        bm;
    logic [15:0] wd;
  } acc_t;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  ref_mem [0:4095];
  logic [7:0]  vdu_mem [0:4095];
  acc_t        expq [$];
  bit          stuck = 0;
  bit          no_stab = 0;
  bit          rd_ovr_en = 0;
  logic [15:0] rd_ovr = 16'h0000;
  int          hold_fix = -1;
  int          stuck_cs = 0;
  int          acc_done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_rd(input logic [10:0] adr, input logic [1:0] sel);
    logic [15:0] r;
    r = 16'h0000;
    if (sel[0]) r[7:0]  = ref_mem[{adr, 1'b0}];
    if (sel[1]) r[15:8] = ref_mem[{adr, 1'b1}];
    return r;
  endfunction

  // One Wishbone transfer; lat = clock edges from request to visible ack.
  task automatic wb_xfer(input logic we, input logic [10:0] adr, input logic [1:0] sel,
                         input logic [15:0] dat, output logic [15:0] rdat, output int lat);
    acc_t e;
    bit   got;
    if (sel != 2'b00 && !stuck) begin
      e.we   = ~we;
      e.addr = {adr, sel == 2'b10};
      e.bm   = (sel != 2'b11);
      e.wd   = (sel == 2'b01) ? {8'h00, dat[7:0]} :
               (sel == 2'b10) ? {dat[15:8], 8'h00} : dat;
      expq.push_back(e);
    end
    @(posedge clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_sel_i = sel;  wb_dat_i = dat;
    lat = 0; got = 0;
    while (!got && lat < 2000) begin
      @(posedge clk); lat++;
      @(negedge clk); got = (wb_ack_o === 1'b1);
    end
    if (!got) chk("ack_timeout", 32'd0, 32'd1);
    rdat = wb_dat_o;
    if (we && !stuck) begin
      if (sel[0]) ref_mem[{adr, 1'b0}] = dat[7:0];
      if (sel[1]) ref_mem[{adr, 1'b1}] = dat[15:8];
    end
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(negedge clk);
    chk("ack_pulse", {31'd0, wb_ack_o}, 32'd0);
  endtask

  // Behavioural VDU: ready drops to accept, rises again when done.
  initial begin : vdu_model
    acc_t got, e;
    int   d1, h;
    ready = 1'b1;
    rd_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (stuck) begin
        if (vdu_cs === 1'b1) stuck_cs++;
      end else if (vdu_cs === 1'b1) begin
        got = {vdu_we, vdu_addr, byte_m, wr_data};
        if (expq.size() == 0) begin
          chk("vdu_unexpected_access", {2'd0, got}, 32'd0);
        end else begin
          e = expq.pop_front();
          chk("vdu_we", {31'd0, got.we}, {31'd0, e.we});
          chk("vdu_addr", {20'd0, got.addr}, {20'd0, e.addr});
          chk("byte_m", {31'd0, got.bm}, {31'd0, e.bm});
          if (!e.we) chk("wr_data", {16'd0, got.wd}, {16'd0, e.wd});
        end
        d1 = $urandom_range(0, 3);
        repeat (d1) begin
          @(negedge clk);
          chk("cs_held", {31'd0, vdu_cs}, 32'd1);
          chk("stable_issue", {2'd0, vdu_we, vdu_addr, byte_m, wr_data}, {2'd0, got});
        end
        if (!got.we) begin
          if (got.bm) begin
            vdu_mem[got.addr] = got.addr[0] ? got.wd[15:8] : got.wd[7:0];
          end else begin
            vdu_mem[{got.addr[11:1], 1'b0}] = got.wd[7:0];
            vdu_mem[{got.addr[11:1], 1'b1}] = got.wd[15:8];
          end
        end else if (rd_ovr_en) begin
          rd_data = rd_ovr;
        end else if (got.bm) begin
          rd_data = {8'($urandom), vdu_mem[got.addr]};
        end else begin
          rd_data = {vdu_mem[{got.addr[11:1], 1'b1}], vdu_mem[{got.addr[11:1], 1'b0}]};
        end
        ready = 1'b0;
        @(negedge clk);
        chk("cs_drop", {31'd0, vdu_cs}, 32'd0);
        h = (hold_fix >= 0) ? hold_fix : $urandom_range(0, 3);
        repeat (h) begin
          @(negedge clk);
          if (!no_stab) begin
            chk("cs_low", {31'd0, vdu_cs}, 32'd0);
            chk("stable_done", {2'd0, vdu_we, vdu_addr, byte_m, wr_data}, {2'd0, got});
          end
        end
        ready = 1'b1;
        acc_done++;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "simulation did not finish");
  end

  initial begin : main
    logic [15:0] rdat, expd, wd;
    logic [10:0] adr;
    logic [1:0]  sel;
    logic        we;
    int          lat, lat1, lat2, lat3, base, ack_seen;
    acc_t        e;

    for (int i = 0; i < 4096; i++) begin
      ref_mem[i] = 8'($urandom);
      vdu_mem[i] = ref_mem[i];
    end
    rst = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_sel_i = '0; wb_dat_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cs", {31'd0, vdu_cs}, 32'd0);
    chk("rst_we", {31'd0, vdu_we}, 32'd1);
    chk("rst_bm", {31'd0, byte_m}, 32'd0);
    chk("rst_addr", {20'd0, vdu_addr}, 32'd0);
    chk("rst_wd", {16'd0, wr_data}, 32'd0);
    chk("rst_dat", {16'd0, wb_dat_o}, 32'd0);
    chk("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    chk("rst_tmo", {31'd0, tmo_err}, 32'd0);

    // Random mixed traffic over a small address window
    for (int n = 0; n < 60; n++) begin
      we  = 1'($urandom_range(0, 1));
      sel = 2'($urandom_range(0, 3));
      adr = 11'($urandom_range(0, 7));
      wd  = 16'($urandom);
      expd = ref_rd(adr, sel);
      wb_xfer(we, adr, sel, wd, rdat, lat);
      if (!we) chk("rand_rd", {16'd0, rdat}, {16'd0, expd});
      if (sel == 2'b00) chk("sel00_lat", lat, 1);
    end
    repeat (20) @(posedge clk);
    chk("tmo_clear_after_rand", {31'd0, tmo_err}, 32'd0);

    // Word write
    wb_xfer(1'b1, 11'h010, 2'b11, 16'h1F41, rdat, lat);
    chk("word_wr_lat", lat, 1);
    repeat (12) @(posedge clk);

    // Odd byte read with a fixed VDU return value
    rd_ovr_en = 1; rd_ovr = 16'hFF9C;
    wb_xfer(1'b0, 11'h005, 2'b10, 16'h0000, rdat, lat);
    chk("byte_rd_data", {16'd0, rdat}, 32'h0000_9C00);
    rd_ovr_en = 0;
    repeat (12) @(posedge clk);

    // Read queued behind a slow write must observe that write
    hold_fix = 3;
    base = acc_done;
    wd = 16'($urandom);
    wb_xfer(1'b1, 11'h030, 2'b11, wd, rdat, lat);
    chk("posted_wr_lat", lat, 1);
    wb_xfer(1'b0, 11'h030, 2'b11, 16'h0000, rdat, lat);
    chk("ordered_rd_data", {16'd0, rdat}, {16'd0, wd});
    chk("rd_ack_after_both", acc_done, base + 2);
    hold_fix = -1;
    repeat (12) @(posedge clk);

    // Master abandons a read mid-access
    base = acc_done;
    e = '{we: 1'b1, addr: 12'h0A0, bm: 1'b0, wd: 16'h0000};
    expq.push_back(e);
    @(posedge clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = 11'h050; wb_sel_i = 2'b11;
    repeat (2) @(posedge clk);
    #1 wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    ack_seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (wb_ack_o === 1'b1) ack_seen = 1;
    end
    chk("abort_no_ack", ack_seen, 0);
    chk("abort_completes", acc_done, base + 1);

    // ready stuck high: read times out
    stuck = 1; stuck_cs = 0;
    wb_xfer(1'b0, 11'h040, 2'b10, 16'h0000, rdat, lat);
    chk("tmo_rd_data", {16'd0, rdat}, 32'h0000_FFFF);
    chk("tmo_cs_cycles", stuck_cs, TMO + 1);
    chk("tmo_err_set", {31'd0, tmo_err}, 32'd1);

    // Three writes against a non-accepting VDU: third waits for the first pop
    wb_xfer(1'b1, 11'h070, 2'b11, 16'h1111, rdat, lat1);
    wb_xfer(1'b1, 11'h071, 2'b01, 16'h2222, rdat, lat2);
    wb_xfer(1'b1, 11'h072, 2'b10, 16'h3333, rdat, lat3);
    chk("fifo_w1_lat", lat1, 1);
    chk("fifo_w2_lat", lat2, 1);
    chk("fifo_w3_held", {31'd0, (lat3 >= TMO - 10) && (lat3 <= TMO + 2)}, 32'd1);
    repeat (700) @(posedge clk);
    stuck = 0;

    // tmo_err is sticky across normal traffic
    wd = 16'($urandom);
    wb_xfer(1'b1, 11'h020, 2'b11, wd, rdat, lat);
    wb_xfer(1'b0, 11'h020, 2'b01, 16'h0000, rdat, lat);
    chk("post_tmo_rd", {16'd0, rdat}, {24'd0, wd[7:0]});
    chk("tmo_err_sticky", {31'd0, tmo_err}, 32'd1);

    // Reset while a write sits in WAIT_DONE
    hold_fix = 30; no_stab = 1;
    base = acc_done;
    wd = 16'($urandom);
    wb_xfer(1'b1, 11'h060, 2'b11, wd, rdat, lat);
    for (int i = 0; i < 50 && ready !== 1'b0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_cs", {31'd0, vdu_cs}, 32'd0);
    chk("rst_mid_ack", {31'd0, wb_ack_o}, 32'd0);
    chk("rst_mid_tmo", {31'd0, tmo_err}, 32'd0);
    chk("rst_mid_we", {31'd0, vdu_we}, 32'd1);
    chk("rst_mid_addr", {20'd0, vdu_addr}, 32'd0);
    ack_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (vdu_cs === 1'b1 || wb_ack_o === 1'b1) ack_seen = 1;
    end
    chk("rst_fifo_empty_idle", ack_seen, 0);
    for (int i = 0; i < 60 && acc_done == base; i++) @(negedge clk);
    hold_fix = -1; no_stab = 0;
    repeat (4) @(posedge clk);

    wb_xfer(1'b0, 11'h060, 2'b11, 16'h0000, rdat, lat);
    chk("after_rst_rd", {16'd0, rdat}, {16'd0, wd});
    chk("expq_drained", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
